imem_boot_loader: RTL and testbench

// - Byte-stream boot loader that writes a program into the IF-stage instruction memory

---
 rtl/imem_boot_loader_pkg.sv | 25 ++
 rtl/imem_boot_loader_byte_to_word_packer.sv | 60 ++++++
 rtl/imem_boot_loader.sv | 198 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - state_e        : loader FSM state encoding (3 bits)
//   - BYTES_PER_WORD : stream bytes that make up one 32-bit instruction word
//   - LEN_W          : width of the big-endian word-count field at stream start
//   - WORD_W         : instruction word width
// -----------------------------------------------------------------------------
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int LEN_W          = 16;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

endpackage : imem_boot_loader_pkg

// File: rtl/imem_boot_loader_byte_to_word_packer.sv
// -----------------------------------------------------------------------------
// byte_to_word_packer
// Collects stream bytes MSB-first into a 32-bit instruction word.
// Ports:
//   clk             in   system clock
//   rst_n           in   asynchronous active-low reset
//   clr_i           in   synchronous clear of the partial word and byte count
//   byte_valid_i    in   byte_i is consumed this cycle
//   byte_i          in   stream byte
//   word_o          out  assembled word (valid when word_complete_o = 1)
//   word_complete_o out  this cycle's byte is the last byte of a word
// word_o / word_complete_o are combinational so the caller can register the
// imem write in the same edge that accepts the final byte (1-cycle latency).
// -----------------------------------------------------------------------------
module byte_to_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_complete_o
);

  // Only the first three bytes need storage; the fourth is the live input.
  logic [WORD_W-9:0]     shift_q, shift_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  assign word_complete_o = byte_valid_i && (cnt_q == LAST_BYTE);
  assign word_o          = {shift_q, byte_i};

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[WORD_W-17:0], byte_i};
      // Wraps to 0 after the last byte; stale shift bits are pushed out
      // before the next word completes.
      cnt_d   = cnt_q + BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : byte_to_word_packer

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Byte-stream boot loader driving the write port of the IF-stage instruction
// memory. Holds the pipeline until a checksum-verified load has completed.
// Stream: LEN_HI, LEN_LO (word count N, big-endian), N x 4 bytes MSB-first,
// then one checksum byte equal to the XOR of every preceding byte.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   restart pulse, honoured only in DONE / ERROR
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts a byte this cycle (registered)
//   imem_we    out  1-cycle instruction memory write strobe
//   imem_addr  out  word address (BASE_ADDR + word index, wraps)
//   imem_wdata out  instruction word, held until the next write
//   core_hold  out  pipeline hold (gates PC write enable and IF/ID enable)
//   load_done  out  load completed with matching checksum
//   load_error out  length overflow or checksum mismatch
// -----------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error
);

  // Largest legal word count: the whole memory. One extra bit so the
  // comparison also works when ADDR_W == LEN_W.
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [7:0]          xor_q, xor_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                core_hold_q, core_hold_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;

  logic                accept;
  logic [LEN_W-1:0]    len_full;
  logic                pack_valid;
  logic                pack_clr;
  logic [WORD_W-1:0]   pack_word;
  logic                pack_done;

  // in_ready is a pure function of state, so it never depends on in_valid.
  assign accept     = in_valid && in_ready_q;
  assign len_full   = {len_q[LEN_W-1:8], in_data};
  assign pack_valid = accept && (state_q == ST_DATA);

  byte_to_word_packer u_packer (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr_i           (pack_clr),
    .byte_valid_i    (pack_valid),
    .byte_i          (in_data),
    .word_o          (pack_word),
    .word_complete_o (pack_done)
  );

  always_comb begin
    state_d      = state_q;
    xor_d        = xor_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    pack_clr     = 1'b0;

    unique case (state_q)
      ST_LEN_HI: begin
        if (accept) begin
          len_d[LEN_W-1:8] = in_data;
          xor_d            = xor_q ^ in_data;
          state_d          = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          xor_d = xor_q ^ in_data;
          if (len_full == '0) begin
            state_d = ST_CSUM;
          end else if ({1'b0, len_full} > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          if (pack_done) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = BASE_ADDR + ADDR_W'(word_cnt_q);
            imem_wdata_d = pack_word;
            word_cnt_d   = word_cnt_q + LEN_W'(1);
            if (word_cnt_q + LEN_W'(1) == len_q) begin
              state_d = ST_CSUM;
            end
          end
        end
      end

      ST_CSUM: begin
        if (accept) begin
          state_d = (in_data == xor_q) ? ST_DONE : ST_ERROR;
        end
      end

      ST_DONE, ST_ERROR: begin
        // in_ready is low here, so a byte offered alongside start is left
        // on the bus for LEN_HI to take later.
        if (start) begin
          state_d     = ST_LEN_HI;
          xor_d       = '0;
          len_d       = '0;
          word_cnt_d  = '0;
          imem_addr_d = BASE_ADDR;
          pack_clr    = 1'b1;
        end
      end

      default: begin
        state_d = ST_LEN_HI;
      end
    endcase
  end

  // Status outputs are registered from the next state so they change in
  // the same cycle the FSM does (core_hold falls exactly as load_done rises).
  always_comb begin
    in_ready_d   = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                   (state_d == ST_DATA)   || (state_d == ST_CSUM);
    core_hold_d  = (state_d != ST_DONE);
    load_done_d  = (state_d == ST_DONE);
    load_error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LEN_HI;
      xor_q        <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      xor_q        <= xor_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule : imem_boot_loader

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed + randomized streams for imem_boot_loader. Expected writes,
// accepted-byte counts and final status are derived from the stream bytes
// alone (stream-format rules), then compared against a write monitor.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  imem_boot_loader #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every observed strobe with its address, data and cycle.
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  logic [7:0]  stim[$];
  logic [31:0] words[$];
  int          acc_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_core_hold"},  32'(core_hold),  32'd1);
    chk({tag, "_load_done"},  32'(load_done),  32'd0);
    chk({tag, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  // Builds a stream from the length field, the words queue and a checksum
  // corruption mask.
  task automatic build(input int n_field, input logic [7:0] csum_flip);
    logic [7:0] x;
    stim = {};
    stim.push_back(8'(n_field >> 8));
    stim.push_back(8'(n_field));
    foreach (words[i]) begin
      stim.push_back(words[i][31:24]);
      stim.push_back(words[i][23:16]);
      stim.push_back(words[i][15:8]);
      stim.push_back(words[i][7:0]);
    end
    x = 8'h00;
    foreach (stim[i]) x = x ^ stim[i];
    stim.push_back(x ^ csum_flip);
  endtask

  // Restart from DONE/ERROR. A byte is offered during the start pulse; it
  // must not be consumed.
  task automatic do_start(input string tag);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_start_in_ready"},   32'(in_ready),   32'd1);
    chk({tag, "_start_load_error"}, 32'(load_error), 32'd0);
    chk({tag, "_start_load_done"},  32'(load_done),  32'd0);
    chk({tag, "_start_core_hold"},  32'(core_hold),  32'd1);
    chk({tag, "_start_imem_addr"},  32'(imem_addr),  32'd0);
  endtask

  // Drives stim (entered and left at a negedge), then checks against the
  // stream-format reference.
  task automatic run_stream(input string tag, input int gap_pct);
    int         n, nw, exp_acc, b, g;
    logic [7:0] x;
    logic       exp_done;
    acc_cyc = {};
    wr_addr = {};
    wr_data = {};
    wr_cyc  = {};
    foreach (stim[i]) begin
      g = 0;
      while (gap_pct > 0 && g < 8 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
        g++;
      end
      if (in_ready !== 1'b1) break;
      in_valid = 1'b1;
      in_data  = stim[i];
      acc_cyc.push_back(cyc + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);

    // Reference: what the stream itself says should happen.
    n = {stim[0], stim[1]};
    if (n > 256) begin
      nw       = 0;
      exp_acc  = 2;
      exp_done = 1'b0;
    end else begin
      nw      = n;
      exp_acc = 2 + 4 * n + 1;
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) x = x ^ stim[i];
      exp_done = (stim[2 + 4 * n] == x);
    end

    // Status is checked at the first sample after the final accepted byte.
    chk({tag, "_accepted"},   32'(acc_cyc.size()), 32'(exp_acc));
    chk({tag, "_load_done"},  32'(load_done),      32'(exp_done));
    chk({tag, "_load_error"}, 32'(load_error),     32'(!exp_done));
    chk({tag, "_core_hold"},  32'(core_hold),      32'(!exp_done));
    chk({tag, "_in_ready"},   32'(in_ready),       32'd0);

    repeat (3) @(negedge clk);
    chk({tag, "_wr_count"}, 32'(wr_data.size()), 32'(nw));
    for (int w = 0; w < nw && w < wr_data.size(); w++) begin
      b = 2 + 4 * w;
      chk({tag, "_wr_data"}, wr_data[w], {stim[b], stim[b+1], stim[b+2], stim[b+3]});
      chk({tag, "_wr_addr"}, 32'(wr_addr[w]), 32'(w % 256));
      if (b + 3 < acc_cyc.size())
        chk({tag, "_wr_cycle"}, 32'(wr_cyc[w]), 32'(acc_cyc[b + 3]));
    end
    $display("stream %s: N=%0d accepted=%0d writes=%0d done=%0b error=%0b",
             tag, n, acc_cyc.size(), wr_data.size(), load_done, load_error);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    repeat (3) @(negedge clk);
    chk_reset("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("rst_release");

    // N=2 good stream, back-to-back bytes.
    words = {32'h20080005, 32'h2009000A};
    build(2, 8'h00);
    run_stream("n2_good", 0);

    // Same stream with a corrupted checksum.
    do_start("n2_bad");
    build(2, 8'h01);
    run_stream("n2_bad", 0);
    do_start("after_err");

    // Empty program.
    words = {};
    build(0, 8'h00);
    run_stream("n0", 0);

    // Length overflow: 257 words in a 256-word memory.
    do_start("n257");
    words = {};
    build(257, 8'h00);
    run_stream("n257", 0);

    // N=2 stream with random gaps in in_valid.
    do_start("n2_gaps");
    words = {32'h20080005, 32'h2009000A};
    build(2, 8'h00);
    run_stream("n2_gaps", 50);

    // Randomized programs, some with a corrupted checksum.
    for (int t = 0; t < 6; t++) begin
      do_start("rnd");
      words = {};
      for (int k = 0; k < int'($urandom_range(6, 1)); k++) words.push_back($urandom);
      build(words.size(), (t % 3 == 2) ? 8'(1 << $urandom_range(7)) : 8'h00);
      run_stream("rnd", (t % 2 == 1) ? 50 : 0);
    end

    // Reset in the middle of word 1: partial word discarded, no write.
    do_start("mid_rst");
    words = {32'h20080005, 32'h2009000A};
    build(2, 8'h00);
    wr_data = {};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = stim[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_reset("mid_rst_low");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("mid_rst_release");
    chk("mid_rst_no_write", 32'(wr_data.size()), 32'd0);
    run_stream("after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_imem_boot_loader
